vend_ctrl: RTL and testbench

//  Vending front-end FSM, directly upstream of the coin counter. Takes raw coin

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_ctrl_change_pick.sv | 30 +++
 rtl/vend_ctrl.sv | 156 +++++++++++++++
 tb/tb_vend_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending front-end: FSM state codes, coin values
// and a helper that maps a single coin strobe to its value in cents.
package vend_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VEND   = 2'd1;
  localparam logic [1:0] ST_CHANGE = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [7:0] NICKEL          = 8'd5;
  localparam logic [7:0] DIME            = 8'd10;
  localparam logic [7:0] NICKEL_DIME     = 8'd15;
  localparam logic [7:0] QUARTER         = 8'd25;
  localparam logic [7:0] MAX_VEND_CHANGE = 8'd20;

  // Only meaningful when exactly one strobe is high; multi-coin cycles are rejected.
  function automatic logic [7:0] coin_value(input logic n, input logic d, input logic q);
    logic [7:0] v;
    v = 8'd0;
    if (n)      v = NICKEL;
    else if (d) v = DIME;
    else if (q) v = QUARTER;
    return v;
  endfunction

endpackage

// File: rtl/vend_ctrl_change_pick.sv
// Greedy change selector: picks the largest payout pulse that fits in rem and
// reports how much that pulse removes from rem.
module vend_ctrl_change_pick
  import vend_pkg::*;
(
  input  logic [7:0] i_rem,
  output logic [3:0] o_sel,   // {two_dime, nickel_dime, dime, nickel}
  output logic [7:0] o_dec
);

  // NOTE: every output gets a default first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    o_sel = 4'b0000;
    o_dec = 8'd0;
    if (i_rem >= MAX_VEND_CHANGE) begin
      o_sel = 4'b1000;
      o_dec = MAX_VEND_CHANGE;
    end else if (i_rem >= NICKEL_DIME) begin
      o_sel = 4'b0100;
      o_dec = NICKEL_DIME;
    end else if (i_rem >= DIME) begin
      o_sel = 4'b0010;
      o_dec = DIME;
    end else if (i_rem >= NICKEL) begin
      o_sel = 4'b0001;
      o_dec = NICKEL;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending front-end FSM: accepts/rejects coins against PRICE, pulses dispense
// once per sale and sequences change or refund pulses into the coin counter.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 35,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       cancel,
  input  logic       use_exact,
  output logic       nickel_acc,
  output logic       dime_acc,
  output logic       quarter_acc,
  output logic       nickel_out,
  output logic       dime_out,
  output logic       nickel_dime_out,
  output logic       two_dime_out,
  output logic       dispense,
  output logic       coin_reject,
  output logic [7:0] credit,
  output logic       busy
);

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam int         SW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  logic [1:0]    r_state;
  logic [7:0]    r_credit;
  logic [7:0]    r_rem;
  logic [SW-1:0] r_settle_cnt;
  logic          r_nickel_acc, r_dime_acc, r_quarter_acc;
  logic          r_nickel_out, r_dime_out, r_nickel_dime_out, r_two_dime_out;
  logic          r_dispense, r_coin_reject;

  logic [1:0] w_coin_cnt;
  logic       w_any_coin;
  logic       w_multi_coin;
  logic [8:0] w_sum;
  logic [3:0] w_sel;
  logic [7:0] w_dec;
  logic [7:0] w_rem_next;

  assign w_coin_cnt   = 2'(nickel_in) + 2'(dime_in) + 2'(quarter_in);
  assign w_any_coin   = (w_coin_cnt != 2'd0);
  assign w_multi_coin = (w_coin_cnt > 2'd1);
  assign w_sum        = {1'b0, r_credit} + {1'b0, coin_value(nickel_in, dime_in, quarter_in)};
  assign w_rem_next   = r_rem - w_dec;

  vend_ctrl_change_pick u_change_pick (
    .i_rem (r_rem),
    .o_sel (w_sel),
    .o_dec (w_dec)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_credit          <= 8'd0;
      r_rem             <= 8'd0;
      r_settle_cnt      <= '0;
      r_nickel_acc      <= 1'b0;
      r_dime_acc        <= 1'b0;
      r_quarter_acc     <= 1'b0;
      r_nickel_out      <= 1'b0;
      r_dime_out        <= 1'b0;
      r_nickel_dime_out <= 1'b0;
      r_two_dime_out    <= 1'b0;
      r_dispense        <= 1'b0;
      r_coin_reject     <= 1'b0;
    end else begin
      // Pulses default low each cycle; branches below raise at most one counter pulse.
      r_nickel_acc      <= 1'b0;
      r_dime_acc        <= 1'b0;
      r_quarter_acc     <= 1'b0;
      r_nickel_out      <= 1'b0;
      r_dime_out        <= 1'b0;
      r_nickel_dime_out <= 1'b0;
      r_two_dime_out    <= 1'b0;
      r_dispense        <= 1'b0;
      r_coin_reject     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cancel) begin
            r_coin_reject <= w_any_coin;
            if (r_credit != 8'd0) begin
              r_rem    <= r_credit;
              r_credit <= 8'd0;
              r_state  <= ST_CHANGE;
            end
          end else if (w_multi_coin) begin
            r_coin_reject <= 1'b1;
          end else if (w_any_coin) begin
            if (use_exact && (w_sum > {1'b0, PRICE_C})) begin
              r_coin_reject <= 1'b1;
            end else begin
              r_nickel_acc  <= nickel_in;
              r_dime_acc    <= dime_in;
              r_quarter_acc <= quarter_in;
              if (w_sum >= {1'b0, PRICE_C}) begin
                r_rem    <= w_sum[7:0] - PRICE_C;
                r_credit <= 8'd0;
                r_state  <= ST_VEND;
              end else begin
                r_credit <= w_sum[7:0];
              end
            end
          end
        end

        ST_VEND: begin
          r_dispense   <= 1'b1;
          r_settle_cnt <= SETTLE_LOAD;
          r_state      <= (r_rem != 8'd0) ? ST_CHANGE : ST_SETTLE;
        end

        ST_CHANGE: begin
          r_two_dime_out    <= w_sel[3];
          r_nickel_dime_out <= w_sel[2];
          r_dime_out        <= w_sel[1];
          r_nickel_out      <= w_sel[0];
          r_rem             <= w_rem_next;
          r_settle_cnt      <= SETTLE_LOAD;
          if (w_rem_next == 8'd0) r_state <= ST_SETTLE;
        end

        default: begin
          if (r_settle_cnt == '0) r_state <= ST_IDLE;
          else                    r_settle_cnt <= r_settle_cnt - 1'b1;
        end
      endcase

      if ((r_state != ST_IDLE) && w_any_coin) r_coin_reject <= 1'b1;
    end
  end

  assign nickel_acc      = r_nickel_acc;
  assign dime_acc        = r_dime_acc;
  assign quarter_acc     = r_quarter_acc;
  assign nickel_out      = r_nickel_out;
  assign dime_out        = r_dime_out;
  assign nickel_dime_out = r_nickel_dime_out;
  assign two_dime_out    = r_two_dime_out;
  assign dispense        = r_dispense;
  assign coin_reject     = r_coin_reject;
  assign credit          = r_credit;
  assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl (PRICE=35, SETTLE_CYC=2): a per-cycle vector
// table plus a hand-written reset-during-change sequence.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       nickel_in, dime_in, quarter_in, cancel, use_exact;
  logic       nickel_acc, dime_acc, quarter_acc;
  logic       nickel_out, dime_out, nickel_dime_out, two_dime_out;
  logic       dispense, coin_reject, busy;
  logic [7:0] credit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE(35), .SETTLE_CYC(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .nickel_in       (nickel_in),
    .dime_in         (dime_in),
    .quarter_in      (quarter_in),
    .cancel          (cancel),
    .use_exact       (use_exact),
    .nickel_acc      (nickel_acc),
    .dime_acc        (dime_acc),
    .quarter_acc     (quarter_acc),
    .nickel_out      (nickel_out),
    .dime_out        (dime_out),
    .nickel_dime_out (nickel_dime_out),
    .two_dime_out    (two_dime_out),
    .dispense        (dispense),
    .coin_reject     (coin_reject),
    .credit          (credit),
    .busy            (busy)
  );

  // Input bits {nickel, dime, quarter, cancel, use_exact}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_N    = 5'b10000;
  localparam logic [4:0] I_D    = 5'b01000;
  localparam logic [4:0] I_Q    = 5'b00100;
  localparam logic [4:0] I_C    = 5'b00010;
  localparam logic [4:0] I_UE   = 5'b00001;

  // Output bits {nacc, dacc, qacc, nout, dout, ndout, tdout, dispense, reject, busy}
  localparam logic [9:0] P_NONE  = 10'd0;
  localparam logic [9:0] P_NACC  = 10'b1000000000;
  localparam logic [9:0] P_DACC  = 10'b0100000000;
  localparam logic [9:0] P_QACC  = 10'b0010000000;
  localparam logic [9:0] P_NOUT  = 10'b0001000000;
  localparam logic [9:0] P_DOUT  = 10'b0000100000;
  localparam logic [9:0] P_NDOUT = 10'b0000010000;
  localparam logic [9:0] P_TDOUT = 10'b0000001000;
  localparam logic [9:0] P_DISP  = 10'b0000000100;
  localparam logic [9:0] P_REJ   = 10'b0000000010;
  localparam logic [9:0] P_BUSY  = 10'b0000000001;

  typedef struct packed {
    logic [4:0] in;
    logic [9:0] exp_p;
    logic [7:0] exp_credit;
  } vec_t;

  vec_t vecs[$];

  logic [9:0] w_act_p;
  assign w_act_p = {nickel_acc, dime_acc, quarter_acc, nickel_out, dime_out,
                    nickel_dime_out, two_dime_out, dispense, coin_reject, busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {nickel_in, dime_in, quarter_in, cancel, use_exact} = in;
  endtask

  // One cycle: drive on the falling edge, sample just after the rising edge.
  task automatic cycle(input logic [4:0] in);
    @(negedge clk);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(I_NONE);
    #3;
    check("reset pulses", 32'(w_act_p), 32'(P_NONE));
    check("reset credit", 32'(credit), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sale at exact price, then a coin rejected during SETTLE.
    vecs.push_back('{I_Q,        P_QACC,                  8'd25});
    vecs.push_back('{I_D,        P_DACC  | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_DISP  | P_BUSY,        8'd0});
    vecs.push_back('{I_D,        P_REJ   | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_NONE,                  8'd0});
    // Overpay by 15: dispense then one nickel_dime pulse.
    vecs.push_back('{I_Q,        P_QACC,                  8'd25});
    vecs.push_back('{I_Q,        P_QACC  | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_DISP  | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_NDOUT | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_BUSY,                  8'd0});
    vecs.push_back('{I_NONE,     P_NONE,                  8'd0});
    // use_exact: overpaying coin rejected, exact completion accepted.
    vecs.push_back('{I_Q | I_UE, P_QACC,                  8'd25});
    vecs.push_back('{I_Q | I_UE, P_REJ,                   8'd25});
    vecs.push_back('{I_D | I_UE, P_DACC  | P_BUSY,        8'd0});
    vecs.push_back('{I_UE,       P_DISP  | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_BUSY,                  8'd0});
    vecs.push_back('{I_NONE,     P_NONE,                  8'd0});
    // Two coins at once rejected.
    vecs.push_back('{I_N | I_D,  P_REJ,                   8'd0});
    // Three dimes then cancel: 20 + 10 refund, coin during CHANGE rejected.
    vecs.push_back('{I_D,        P_DACC,                  8'd10});
    vecs.push_back('{I_D,        P_DACC,                  8'd20});
    vecs.push_back('{I_D,        P_DACC,                  8'd30});
    vecs.push_back('{I_C,        P_BUSY,                  8'd0});
    vecs.push_back('{I_N,        P_TDOUT | P_REJ | P_BUSY, 8'd0});
    vecs.push_back('{I_NONE,     P_DOUT  | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_BUSY,                  8'd0});
    vecs.push_back('{I_NONE,     P_NONE,                  8'd0});
    // Cancel with zero credit ignored; cancel beats a simultaneous coin.
    vecs.push_back('{I_C,        P_NONE,                  8'd0});
    vecs.push_back('{I_N,        P_NACC,                  8'd5});
    vecs.push_back('{I_C | I_D,  P_REJ   | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_NOUT  | P_BUSY,        8'd0});
    vecs.push_back('{I_NONE,     P_BUSY,                  8'd0});
    vecs.push_back('{I_NONE,     P_NONE,                  8'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].in);
      check($sformatf("vec%0d pulses", i), 32'(w_act_p), 32'(vecs[i].exp_p));
      check($sformatf("vec%0d credit", i), 32'(credit), 32'(vecs[i].exp_credit));
    end

    // Reset asserted between edges while a refund is in progress.
    cycle(I_D);
    cycle(I_D);
    cycle(I_D);
    cycle(I_C);
    check("rstseq cancel busy", 32'(w_act_p), 32'(P_BUSY));
    cycle(I_NONE);
    check("rstseq first change", 32'(w_act_p), 32'(P_TDOUT | P_BUSY));
    drive(I_NONE);
    #2;
    rst = 1'b1;
    #1;
    check("rstseq async pulses", 32'(w_act_p), 32'(P_NONE));
    check("rstseq async credit", 32'(credit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(I_NONE);
      check($sformatf("rstseq idle%0d pulses", k), 32'(w_act_p), 32'(P_NONE));
      check($sformatf("rstseq idle%0d credit", k), 32'(credit), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
